// File: rtl/z_result_stage.sv
// Result-capture stage behind the ALU: holds one narrow or wide result in the Z pair
// and streams it to the bus as one or two beats, with capture-time flags and a retire count.
//
// state   | meaning
// EMPTY   | no result held, ready to capture
// SEND_LO | low word on the bus (only beat for narrow results)
// SEND_HI | high word on the bus (second beat of a wide result)
module z_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_lo,
    input  logic [WIDTH-1:0] in_hi,
    input  logic             in_wide,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] zlo;
    logic [WIDTH-1:0] zhi;
    logic             wide;
    logic             last_beat;
    logic             accept;

    always_comb begin
        last_beat = bus_ready && ((state == SEND_LO && !wide) || state == SEND_HI);
        in_ready  = clear && (state == EMPTY || last_beat);
        accept    = in_valid && in_ready;
    end

    // Bus word comes straight from the Z pair, selected by the registered beat flag.
    assign bus_out = bus_hi ? zhi : zlo;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= EMPTY;
            zlo       <= '0;
            zhi       <= '0;
            wide      <= 1'b0;
            bus_valid <= 1'b0;
            bus_hi    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            retired   <= '0;
        end else begin
            if (last_beat && retired != '1) begin
                retired <= retired + 1'b1;
            end

            // A capture on the last beat wins over the return to EMPTY, so no bubble.
            if (accept) begin
                zlo       <= in_lo;
                zhi       <= in_wide ? in_hi : '0;
                wide      <= in_wide;
                flag_z    <= (in_lo == '0) && (!in_wide || in_hi == '0);
                flag_n    <= in_wide ? in_hi[WIDTH-1] : in_lo[WIDTH-1];
                bus_valid <= 1'b1;
                bus_hi    <= 1'b0;
                state     <= SEND_LO;
            end else if (state == SEND_LO && bus_ready && wide) begin
                bus_hi    <= 1'b1;
                state     <= SEND_HI;
            end else if (last_beat) begin
                bus_valid <= 1'b0;
                bus_hi    <= 1'b0;
                state     <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_z_result_stage.sv
// Bench for z_result_stage: directed scenarios then random traffic, all checked against
// a beat-queue model of the stage.
module tb_z_result_stage;

    localparam int W    = 32;
    localparam int CW   = 4;
    localparam int MAXR = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_lo = '0;
    logic [W-1:0]  in_hi = '0;
    logic          in_wide = 1'b0;
    logic [W-1:0]  bus_out;
    logic          bus_valid;
    logic          bus_ready = 1'b0;
    logic          bus_hi;
    logic          flag_z;
    logic          flag_n;
    logic [CW-1:0] retired;

    z_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_wide   (in_wide),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_hi    (bus_hi),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .retired   (retired)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: queue of pending beats {is_high, word}, flags of last capture, retire count.
    logic [W:0] beats[$];
    logic       m_z = 1'b0;
    logic       m_n = 1'b0;
    int         m_ret = 0;
    bit         known = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] lo, input logic [W-1:0] hi,
                        input logic wd, input logic br, input logic cl);
        logic exp_rdy;
        @(negedge clock);
        in_valid  = v;
        in_lo     = lo;
        in_hi     = hi;
        in_wide   = wd;
        bus_ready = br;
        clear     = cl;
        #1;
        exp_rdy = cl && (beats.size() == 0 || (beats.size() == 1 && br));
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (known) begin
            check("bus_valid", {63'd0, bus_valid}, {63'd0, beats.size() != 0});
            if (beats.size() != 0) begin
                check("bus_out", {32'd0, bus_out}, {32'd0, beats[0][W-1:0]});
                check("bus_hi", {63'd0, bus_hi}, {63'd0, beats[0][W]});
            end
            check("flag_z", {63'd0, flag_z}, {63'd0, m_z});
            check("flag_n", {63'd0, flag_n}, {63'd0, m_n});
            check("retired", {60'd0, retired}, 64'(m_ret));
        end
        if (!cl) begin
            beats.delete();
            m_z   = 1'b0;
            m_n   = 1'b0;
            m_ret = 0;
            known = 1'b1;
        end else if (known) begin
            if (beats.size() != 0 && br) begin
                void'(beats.pop_front());
                if (beats.size() == 0) m_ret = (m_ret == MAXR) ? MAXR : m_ret + 1;
            end
            if (v && exp_rdy) begin
                beats.push_back({1'b0, lo});
                if (wd) beats.push_back({1'b1, hi});
                m_z = (lo == 0) && (!wd || hi == 0);
                m_n = wd ? hi[W-1] : lo[W-1];
            end
        end
    endtask

    task automatic idle(input logic br);
        step(1'b0, '0, '0, 1'b0, br, 1'b1);
    endtask

    logic [W-1:0] rot_src;
    logic [W-1:0] rot_res;

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // narrow rotate-left result
        rot_src = 32'h8000_0001;
        rot_res = {rot_src[W-2:0], rot_src[W-1]};
        step(1'b1, rot_res, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("plan_narrow_retired", {60'd0, retired}, 64'd1);

        // wide result, low then high beat
        step(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("plan_wide_flag_n", {63'd0, flag_n}, 64'd1);

        // back-pressure on a narrow result
        step(1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        check("plan_bp_retired", {60'd0, retired}, 64'd3);

        // back-to-back narrow results
        step(1'b1, 32'hA, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'hB, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'hC, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("plan_b2b_retired", {60'd0, retired}, 64'd6);

        // zero results: in_hi ignored for narrow, counted for wide
        step(1'b1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        check("plan_zero_narrow", {63'd0, flag_z}, 64'd1);
        step(1'b1, 32'h0, 32'h1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("plan_zero_wide", {63'd0, flag_z}, 64'd0);

        // reset during the high beat of a wide result
        step(1'b1, 32'h5, 32'h8000_0006, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // saturate the retire counter
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("sat_retired", {60'd0, retired}, 64'(MAXR));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 32'h0 : $urandom,
                 $urandom_range(0, 7) == 0 ? 32'h0 : $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 59) != 0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z_result_stage.md
Name: z_result_stage

Overview:
- Result-capture stage directly downstream of the ALU datapath, including the rotate-left and rotate-right units.
- Accepts one ALU result per valid/ready handshake. A result is narrow (low word only, e.g. rotate/shift/logic) or wide (high and low words, e.g. mul/div).
- Holds the result in the Z register pair and streams it onto the bus as one beat (narrow) or two beats (wide: low then high).
- Computes zero/negative flags at capture and keeps a saturating count of retired results.

Parameters:
- WIDTH, 32: data word width; result is up to 2*WIDTH.
- CNT_W, 16: width of the retired-result counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU result present on in_lo/in_hi/in_wide.
- in_ready  out  1  stage can accept a result this cycle.
- in_lo  in  WIDTH  low word; for narrow ops this is the whole result, e.g. rotator R.
- in_hi  in  WIDTH  high word; ignored when in_wide=0.
- in_wide  in  1  1 = two-word result.
- bus_out  out  WIDTH  word being driven to the bus.
- bus_valid  out  1  bus_out is valid.
- bus_ready  in  1  bus consumer takes bus_out this cycle.
- bus_hi  out  1  1 = current beat is the high word.
- flag_z  out  1  zero flag of the last captured result.
- flag_n  out  1  negative flag of the last captured result.
- retired  out  CNT_W  results fully drained; saturates at all-ones.

Behaviour:
- Reset (clear=0 at a rising edge) forces the following, regardless of handshakes in progress:
  - state=EMPTY.
  - bus_out=0, bus_valid=0, bus_hi=0.
  - flag_z=0, flag_n=0, retired=0.
  - Z registers cleared.
- in_ready is combinational and is forced to 0 while clear=0.
- States:
  - EMPTY: bus_valid=0, in_ready=1. On in_valid, capture at the edge: zlo<=in_lo, zhi<=(in_wide ? in_hi : 0), wide<=in_wide; go to SEND_LO.
  - SEND_LO: bus_valid=1, bus_out=zlo, bus_hi=0.
    - If bus_ready and wide: go to SEND_HI.
    - If bus_ready and not wide: the beat is the last beat.
    - If not bus_ready: hold; bus_out and bus_hi stay stable.
  - SEND_HI: bus_valid=1, bus_out=zhi, bus_hi=1. If bus_ready: the beat is the last beat; otherwise hold.
- Last-beat completion:
  - retired increments by 1, or holds if already all-ones.
  - If in_valid is asserted in the same cycle, the new result is captured and the next state is SEND_LO, so there is no bubble.
  - Otherwise the next state is EMPTY.
- in_ready equation: (state==EMPTY) | (state==SEND_LO & ~wide & bus_ready) | (state==SEND_HI & bus_ready), ANDed with clear.
- Latency: a result accepted at edge k drives its first beat at cycle k+1. Sustained throughput is 1 narrow result/cycle or 1 wide result per 2 cycles.
- Flags are updated only at capture, in the same edge, and held otherwise:
  - flag_z = (in_lo==0) & (~in_wide | in_hi==0).
  - flag_n = in_wide ? in_hi[WIDTH-1] : in_lo[WIDTH-1].
- in_hi is ignored for narrow results: nonzero in_hi with in_wide=0 changes neither flag_z nor zhi.
- Data registers drive bus_out directly, with no combinational path from in_* to bus_out.
- in_valid with in_ready=0 is not captured. The upstream stage must hold its data; this stage does not buffer it.

Test Plan:
- Narrow rotate result: reset, then in_lo=32'h00000003 (ROL 32'h80000001 by 1), in_wide=0, bus_ready=1 → next cycle one beat bus_out=32'h00000003, bus_hi=0; flag_z=0, flag_n=0; retired=1; state returns to EMPTY.
- Wide result: in_hi=32'hFFFFFFFF, in_lo=32'h12345678, in_wide=1, bus_ready=1 → beats 32'h12345678 (bus_hi=0) then 32'hFFFFFFFF (bus_hi=1); flag_n=1, flag_z=0; in_ready=0 during the low beat.
- Back-pressure: narrow in_lo=32'hDEADBEEF, bus_ready=0 for 3 cycles then 1 → bus_valid=1 and bus_out=32'hDEADBEEF stable for 4 cycles, in_ready=0 for 3 cycles, retired increments once.
- Back-to-back narrow results: in_valid held with 32'hA, 32'hB, 32'hC and bus_ready=1 → bus_out A,B,C on consecutive cycles, in_ready stays 1, retired=3.
- Zero result: narrow in_lo=0, in_hi=32'h1 → flag_z=1 and bus_out=0. Then wide in_lo=0, in_hi=32'h1 → flag_z=0.
- Reset mid-operation: clear=0 during SEND_HI of a wide result → next cycle bus_valid=0, flags=0, retired=0; in_ready=0 while clear=0 and 1 after clear returns to 1.
